pmn_seq_monitor: RTL and testbench
==================================

Name: pmn_seq_monitor

Overview:
- Downstream consumer of the p/m/n Mealy outputs of the a/b control FSM.
- Samples {p,m,n} each qualified cycle and classifies it into a symbol.
- Detects the overlapping target sequence P,M,N,P,P,P.
- Counts matches and timestamps each match into a 4-deep event FIFO, which a host drains with a valid/ready handshake.

Parameters:
- TS_W, 16, width of free-running timestamp counter and of FIFO entries.
- CNT_W, 8, width of saturating match counter.
- DEPTH, 4, event FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear: FSM, counter, FIFO, ovf.
- in_vld  in  1  qualifies p/m/n this cycle.
- p  in  1  upstream FSM output p.
- m  in  1  upstream FSM output m.
- n  in  1  upstream FSM output n.
- det  out  1  one-cycle pulse, registered, on sequence completion.
- match_cnt  out  CNT_W  saturating match count.
- evt_vld  out  1  FIFO non-empty.
- evt_rdy  in  1  host accepts head entry when evt_vld=1.
- evt_ts  out  TS_W  head-of-FIFO timestamp; value is don't-care when evt_vld=0.
- ovf  out  1  sticky: a match was dropped because the FIFO was full.
- fifo_lvl  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_b=0, async): FSM=D0, det=0, match_cnt=0, FIFO empty (evt_vld=0, fifo_lvl=0), ovf=0, ts=0.
- Timestamp ts: increments by 1 every clock after reset release; wraps 2^TS_W-1→0; not affected by clr or in_vld.
- Symbol classification, only when in_vld=1:
  - {p,m,n}=100 → P.
  - {p,m,n}=010 → M.
  - {p,m,n}=001 → N.
  - Any other pattern (000, or multi-hot such as 011) → X.
- in_vld=0: FSM holds its state; no symbol is consumed.
- FSM states D0..D5 = length of matched prefix. Transitions (symbols not listed → D0):
  - D0: P→D1.
  - D1: M→D2, P→D1.
  - D2: N→D3, P→D1.
  - D3: P→D4.
  - D4: P→D5, M→D2.
  - D5: P→match, next D1; M→D2.
- Matches overlap: a trailing P seeds the next match.
- On a match (sampled at edge k):
  - det=1 during cycle k+1 only.
  - match_cnt increments at the same edge; saturates at 2^CNT_W-1.
  - ts value present at edge k is pushed to the FIFO; the entry is visible at evt_ts in cycle k+1 if the FIFO was empty.
- Pop occurs when evt_vld & evt_rdy at the edge; FIFO order is strictly in-order.
- Push while full with a simultaneous pop: both occur, nothing is dropped, fifo_lvl is unchanged.
- Push while full without a pop: entry is dropped, ovf←1. ovf clears only on clr or reset.
- Push and pop requested in the same cycle on an empty FIFO: no pop occurs (evt_vld=0); the push occurs.
- clr=1 at an edge:
  - FSM→D0, match_cnt→0, FIFO flushed, ovf→0, det→0.
  - clr has priority over a match and over a pop in the same cycle; the symbol sampled that cycle is discarded.
- Async reset mid-sequence: all state returns to reset values immediately; the partial prefix is lost.

Test Plan:
1. Reset release, in_vld=1, symbols P,M,N,P,P,P at ts=2..7 → det=1 in the cycle after the ts=7 edge, match_cnt=1, evt_vld=1, evt_ts=7, fifo_lvl=1.
2. Overlap: P,M,N,P,P,P,M,N,P,P,P with evt_rdy=0 → two det pulses, match_cnt=2, FIFO holds two timestamps 5 symbols apart.
3. Gaps and breaks:
   - Insert in_vld=0 cycles inside the sequence → still one match.
   - Insert a 011 symbol after P,M,N → no match, FSM back to D0.
   - P,M,N,P,M,N,P,P,P → exactly one match (via D4 on M→D2).
4. FIFO: 5 matches with evt_rdy=0 → fifo_lvl=4, ovf=1, first 4 timestamps retained in order; then evt_rdy=1 drains 4 entries and evt_vld falls.
5. Simultaneous events:
   - FIFO full with evt_rdy=1 on the match cycle → no drop, ovf stays 0.
   - clr asserted on the match cycle → det=0, match_cnt=0, FIFO empty.
6. Saturation/wrap (CNT_W=2, TS_W=4): 5 matches → match_cnt=3; stored timestamps reflect the ts wrap 15→0.

Source files
------------

// File: rtl/pmn_seq_monitor.sv
// Monitors qualified {p,m,n} symbols for the overlapping sequence P,M,N,P,P,P.
// Counts matches and queues each match timestamp in a small FIFO for the host to drain.
module pmn_seq_monitor #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      clr,
    input  logic                      in_vld,
    input  logic                      p,
    input  logic                      m,
    input  logic                      n,
    output logic                      det,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      evt_vld,
    input  logic                      evt_rdy,
    output logic [TS_W-1:0]           evt_ts,
    output logic                      ovf,
    output logic [$clog2(DEPTH):0]    fifo_lvl
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5} state_e;
    typedef enum logic [1:0] {SYM_X, SYM_P, SYM_M, SYM_N} sym_e;

    state_e             state_q;
    logic               det_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   lvl_q;
    logic               ovf_q;

    sym_e               sym_c;
    logic               match_c;
    logic               empty_c;
    logic               full_c;
    logic               pop_c;
    logic               wr_en_c;
    logic               drop_c;

    // One-hot patterns map to symbols; anything else breaks the sequence.
    always_comb begin
        sym_c = SYM_X;
        unique case ({p, m, n})
            3'b100:  sym_c = SYM_P;
            3'b010:  sym_c = SYM_M;
            3'b001:  sym_c = SYM_N;
            default: sym_c = SYM_X;
        endcase
    end

    assign match_c = in_vld & ~clr & (state_q == D5) & (sym_c == SYM_P);
    assign empty_c = (lvl_q == '0);
    assign full_c  = (lvl_q == LVL_W'(DEPTH));
    assign pop_c   = ~clr & ~empty_c & evt_rdy;
    assign wr_en_c = match_c & (~full_c | pop_c);
    assign drop_c  = match_c & full_c & ~pop_c;

    // Prefix-length FSM; each state is the longest matched prefix of the target.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= D0;
            det_q   <= 1'b0;
        end else if (clr) begin
            state_q <= D0;
            det_q   <= 1'b0;
        end else begin
            det_q <= match_c;
            if (in_vld) begin
                unique case (state_q)
                    D0: state_q <= (sym_c == SYM_P) ? D1 : D0;
                    D1: state_q <= (sym_c == SYM_M) ? D2 : (sym_c == SYM_P) ? D1 : D0;
                    D2: state_q <= (sym_c == SYM_N) ? D3 : (sym_c == SYM_P) ? D1 : D0;
                    D3: state_q <= (sym_c == SYM_P) ? D4 : D0;
                    D4: state_q <= (sym_c == SYM_P) ? D5 : (sym_c == SYM_M) ? D2 : D0;
                    D5: state_q <= (sym_c == SYM_P) ? D1 : (sym_c == SYM_M) ? D2 : D0;
                    default: state_q <= D0;
                endcase
            end
        end
    end

    // Free-running timestamp, independent of clr and in_vld.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Saturating match counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            match_cnt_q <= '0;
        end else if (clr) begin
            match_cnt_q <= '0;
        end else if (match_c && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_q <= match_cnt_q + CNT_W'(1);
        end
    end

    // Event FIFO; a push into a full FIFO is kept only when the head pops in the same cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= ts_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en_c && !pop_c) begin
                lvl_q <= lvl_q + LVL_W'(1);
            end else if (!wr_en_c && pop_c) begin
                lvl_q <= lvl_q - LVL_W'(1);
            end
            if (drop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign det       = det_q;
    assign match_cnt = match_cnt_q;
    assign evt_vld   = ~empty_c;
    assign evt_ts    = mem_q[rd_ptr_q];
    assign ovf       = ovf_q;
    assign fifo_lvl  = lvl_q;

endmodule

// File: tb/tb_pmn_seq_monitor.sv
// Bench for pmn_seq_monitor: default-width and narrow (CNT_W=2, TS_W=4) instances share
// one stimulus stream and are compared each cycle against a symbol-history reference model.
module tb_pmn_seq_monitor;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_b;
    logic        clr;
    logic        in_vld;
    logic        p;
    logic        m;
    logic        n;
    logic        evt_rdy;

    logic        det1, vld1, ovf1;
    logic [7:0]  cnt1;
    logic [15:0] ts1;
    logic [2:0]  lvl1;
    logic        det2, vld2, ovf2;
    logic [1:0]  cnt2;
    logic [3:0]  ts2;
    logic [2:0]  lvl2;

    pmn_seq_monitor #(.TS_W(16), .CNT_W(8), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_b(rst_b), .clr(clr), .in_vld(in_vld),
        .p(p), .m(m), .n(n),
        .det(det1), .match_cnt(cnt1), .evt_vld(vld1), .evt_rdy(evt_rdy),
        .evt_ts(ts1), .ovf(ovf1), .fifo_lvl(lvl1)
    );

    pmn_seq_monitor #(.TS_W(4), .CNT_W(2), .DEPTH(DEPTH)) u_dut_s (
        .clk(clk), .rst_b(rst_b), .clr(clr), .in_vld(in_vld),
        .p(p), .m(m), .n(n),
        .det(det2), .match_cnt(cnt2), .evt_vld(vld2), .evt_rdy(evt_rdy),
        .evt_ts(ts2), .ovf(ovf2), .fifo_lvl(lvl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    string       phase    = "init";

    // Reference model: the consumed symbol history, the pending timestamps and a plain count.
    string       tgt = "PMNPPP";
    byte         hist[$];
    int unsigned fq[$];
    int unsigned ts_m    = 0;
    int unsigned count_m = 0;
    bit          ovf_m   = 1'b0;
    bit          det_m   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic byte classify(input logic [2:0] v);
        case (v)
            3'b100:  return "P";
            3'b010:  return "M";
            3'b001:  return "N";
            default: return "X";
        endcase
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        hist.delete();
        fq.delete();
        count_m = 0;
        ovf_m   = 1'b0;
        det_m   = 1'b0;
        ts_m    = 0;
    endtask

    task automatic model_edge(input bit v, input logic [2:0] pmn, input bit r, input bit c);
        bit mt;
        bit full_hit;
        mt = 1'b0;
        if (c) begin
            hist.delete();
            fq.delete();
            count_m = 0;
            ovf_m   = 1'b0;
            det_m   = 1'b0;
        end else begin
            if (v) begin
                hist.push_back(classify(pmn));
                if (hist.size() > 6) void'(hist.pop_front());
                full_hit = (hist.size() == 6);
                for (int i = 0; i < 6 && full_hit; i++) begin
                    if (hist[i] != tgt[i]) full_hit = 1'b0;
                end
                mt = full_hit;
            end
            det_m = mt;
            if (mt) count_m++;
            if (fq.size() > 0 && r) void'(fq.pop_front());
            if (mt) begin
                if (fq.size() < DEPTH) fq.push_back(ts_m);
                else ovf_m = 1'b1;
            end
        end
        ts_m++;
    endtask

    task automatic check_outputs();
        chk("det",      32'(det1), 32'(det_m));
        chk("det_s",    32'(det2), 32'(det_m));
        chk("cnt",      32'(cnt1), sat(count_m, 255));
        chk("cnt_s",    32'(cnt2), sat(count_m, 3));
        chk("evt_vld",  32'(vld1), 32'(fq.size() != 0));
        chk("evt_vld_s",32'(vld2), 32'(fq.size() != 0));
        chk("lvl",      32'(lvl1), 32'(fq.size()));
        chk("lvl_s",    32'(lvl2), 32'(fq.size()));
        chk("ovf",      32'(ovf1), 32'(ovf_m));
        chk("ovf_s",    32'(ovf2), 32'(ovf_m));
        if (fq.size() > 0) begin
            chk("evt_ts",   32'(ts1), fq[0] & 32'hFFFF);
            chk("evt_ts_s", 32'(ts2), fq[0] & 32'hF);
        end
    endtask

    // One cycle: check current outputs, drive inputs at the falling edge, advance the model.
    task automatic cyc(input bit v, input logic [2:0] pmn, input bit r, input bit c);
        check_outputs();
        in_vld  = v;
        {p, m, n} = pmn;
        evt_rdy = r;
        clr     = c;
        model_edge(v, pmn, r, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    // 'P','M','N' one-hot; 'Z' = 000; 'Y' = 011; 'I' = idle (in_vld low, noise on p/m/n).
    task automatic s(input byte ch, input bit r = 1'b0, input bit c = 1'b0);
        case (ch)
            "P":     cyc(1'b1, 3'b100, r, c);
            "M":     cyc(1'b1, 3'b010, r, c);
            "N":     cyc(1'b1, 3'b001, r, c);
            "Z":     cyc(1'b1, 3'b000, r, c);
            "Y":     cyc(1'b1, 3'b011, r, c);
            default: cyc(1'b0, 3'($urandom), r, c);
        endcase
    endtask

    task automatic seq(input string str, input bit r = 1'b0);
        for (int i = 0; i < str.len(); i++) s(str[i], r, 1'b0);
    endtask

    task automatic do_clr();
        s("I", 1'b0, 1'b1);
    endtask

    task automatic async_reset();
        rst_b = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        string pool;
        pool    = "PMNPPPZYI";
        rst_b   = 1'b0;
        clr     = 1'b0;
        in_vld  = 1'b0;
        {p, m, n} = 3'b000;
        evt_rdy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);

        phase = "reset";
        chk("rst_det", 32'(det1), 32'd0);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_vld", 32'(vld1), 32'd0);
        chk("rst_lvl", 32'(lvl1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        rst_b = 1'b1;

        phase = "basic";
        s("I"); s("I");
        seq("PMNPPP");
        chk("t1_det", 32'(det1), 32'd1);
        chk("t1_ts",  32'(ts1),  32'd7);
        chk("t1_lvl", 32'(lvl1), 32'd1);
        chk("t1_cnt", 32'(cnt1), 32'd1);
        s("I");

        phase = "overlap";
        do_clr();
        seq("PMNPPPMNPPP");
        s("I");
        chk("t2_lvl", 32'(lvl1), 32'd2);

        phase = "gaps";
        do_clr();
        seq("PMIINIPIPIP");
        seq("II");
        seq("PMNYPPP");
        seq("II");
        seq("PMNPMNPPP");
        seq("II");

        phase = "fifo_full";
        do_clr();
        for (int i = 0; i < 5; i++) seq("PMNPPP");
        s("I");
        chk("t4_lvl", 32'(lvl1), 32'd4);
        chk("t4_ovf", 32'(ovf1), 32'd1);
        repeat (5) s("I", 1'b1);
        chk("t4_vld", 32'(vld1), 32'd0);

        phase = "full_pop";
        do_clr();
        for (int i = 0; i < 4; i++) seq("PMNPPP");
        seq("PMNPP");
        s("P", 1'b1);
        s("I");
        chk("t5_ovf", 32'(ovf1), 32'd0);

        phase = "empty_push_pop";
        do_clr();
        seq("PMNPP");
        s("P", 1'b1);
        s("I");

        phase = "clr_on_match";
        seq("PMNPP");
        s("P", 1'b0, 1'b1);
        chk("t5_det", 32'(det1), 32'd0);
        chk("t5_cnt", 32'(cnt1), 32'd0);
        chk("t5_lvl", 32'(lvl1), 32'd0);

        phase = "async_rst";
        seq("PMNPP");
        async_reset();
        seq("PPP");
        s("I");

        phase = "sat_wrap";
        for (int i = 0; i < 6; i++) begin
            seq("PMNPPP", 1'b1);
            repeat (i) s("I", 1'b1);
        end
        s("I");

        phase = "random";
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                seq("PMNPPP", 1'($urandom_range(0, 1)));
            end else begin
                s(pool[$urandom_range(0, pool.len() - 1)],
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) == 0);
            end
        end
        s("I");
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
